resource_arbiter: RTL and testbench
===================================

# resource_arbiter

Round-robin arbiter that shares one in-order shared resource among NUM_REQ producer pipelines. It sits between the final request stage of each requester pipeline and the resource's input, and between the resource's output and each requester's consumer-side stage. Each accepted request beat is registered once toward the resource, and its owner index is tracked in a tag FIFO. Resource responses are steered back to the correct requester in issue order, with stall propagated in both directions.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- DATA_W, 32: beat data width
- MAX_OUTSTANDING, 8: tag FIFO depth; power of two, at least 2
- BURST_MAX, 4: beats per grant lock; used only with ARB_BURST_LOCK_EN
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- in_data_from_req  in  NUM_REQ*DATA_W  request data; requester i at bits [i*DATA_W +: DATA_W]
- in_valid_from_req  in  NUM_REQ  request valid
- in_flush_from_req  in  NUM_REQ  flush sideband, travels with the beat
- out_stall_to_req  out  NUM_REQ  request stall back to each requester
- out_data_to_resource  out  DATA_W  registered request data
- out_valid_to_resource  out  1  registered request valid
- out_flush_to_resource  out  1  registered request flush
- in_stall_from_resource  in  1  resource cannot accept
- in_data_from_resource  in  DATA_W  response data
- in_valid_from_resource  in  1  response valid
- in_flush_from_resource  in  1  response flush sideband
- out_stall_to_resource  out  1  response stall
- out_data_to_req  out  NUM_REQ*DATA_W  response data, broadcast to all lanes
- out_valid_to_req  out  NUM_REQ  one-hot response valid
- out_flush_to_req  out  NUM_REQ  one-hot response flush
- in_stall_from_req  in  NUM_REQ  per-requester response stall
- out_err_unexpected_rsp  out  1  sticky; set by a response while the tag FIFO is empty

## Operation
- Request register (data, flush, valid, owner) is "free" when it is not valid, or when it is valid and in_stall_from_resource=0.
- Accept condition: register free AND tag FIFO not full (count + pending push < MAX_OUTSTANDING) AND at least one in_valid_from_req.
- Winner: first valid requester at or after rr_ptr, searching in modular order.
- out_stall_to_req[i] = ~(accept & winner==i). Every non-winner, and every requester while not accepting, sees stall=1.
- On accept:
  - Load data and flush from the winner; set valid; owner = winner.
  - rr_ptr <= (winner+1) mod NUM_REQ.
- If the register is free and there is no accept: valid <= 0.
- Tag push occurs when out_valid_to_resource & ~in_stall_from_resource; push value = owner.
- Response steering is combinational. head = tag FIFO head.
  - out_valid_to_req[head] = in_valid_from_resource & ~empty.
  - out_flush_to_req[head] = in_flush_from_resource & ~empty.
  - out_stall_to_resource = empty | in_stall_from_req[head].
- Tag pop occurs when in_valid_from_resource & ~out_stall_to_resource.
- Push and pop in the same cycle are allowed, including when the FIFO is full (pop frees the slot first) and when it is empty (push is not visible at head until the next cycle).
- A response arriving while the FIFO is empty is dropped, and out_err_unexpected_rsp is set. It clears only on reset.
- Flush carries no arbitration meaning. It is delivered intact with its beat.

## Timing
- Request latency: beat accepted at edge N appears on out_*_to_resource from cycle N+1.
- Throughput: one beat per cycle while the resource is not stalling and the FIFO has room.
- Response path: zero latency, combinational.
- Reset values:
  - out_valid_to_resource=0, out_flush_to_resource=0, out_data_to_resource=0
  - rr_ptr=0, tag FIFO empty, out_err_unexpected_rsp=0
  - out_stall_to_req all 1 (no accept is possible during reset), out_stall_to_resource=1
- Reset mid-operation discards the register contents and all outstanding tags. Responses to those tags after reset flag an error.
- A held stall keeps out_data_to_resource, out_valid_to_resource and out_flush_to_resource stable.

## Configuration
- ARB_BURST_LOCK_EN defined:
  - After a grant, the same requester keeps priority while its valid stays high, for up to BURST_MAX consecutive accepted beats.
  - rr_ptr advances past the requester only when the lock ends (valid drops, or BURST_MAX is reached).
  - The lock counter resets on reset.
- Undefined: pure round-robin; rr_ptr advances after every accept. BURST_MAX is ignored.

## Structure
- Package resource_arb_pkg holds:
  - REQ_IDX_W = $clog2(NUM_REQ) default
  - the owner-index typedef
  - the rr-search function (first set bit at or after pointer)
- Sub-module resource_arb_tag_fifo: synchronous FIFO, width REQ_IDX_W, depth MAX_OUTSTANDING. Ports: push, pop, full, empty, head, count.

## Test plan
- Req0 and req2 valid every cycle, no stalls. Grant order is 0,2,0,2; each beat appears one cycle after its accept.
- All 4 requesters valid with in_stall_from_resource=1 for 3 cycles. The output beat is held; all out_stall_to_req=1; after stall release, grants resume at rr_ptr.
- Resource never responds; 8 beats issued. The 9th request sees stall=1 until one response pops. A same-cycle push and pop at full accepts the beat.
- Responses tagged {1,3,1} with in_stall_from_req[3]=1 for 2 cycles. The second response is held, out_stall_to_resource=1, and lane 3 then receives data 0xA5A5_0003.
- Response with an empty FIFO sets out_err_unexpected_rsp=1, asserts no out_valid_to_req, and the error stays set until reset. Reset asserted mid-burst gives all reset values on the next cycle.
- ARB_BURST_LOCK_EN with BURST_MAX=4, requesters 0 and 1 always valid. Grant order is 0,0,0,0,1,1,1,1.

Source files
------------

// File: rtl/resource_arb_pkg.sv
// resource_arb_pkg: shared index width, owner type and the
// round-robin search helper for the resource arbiter.
package resource_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int REQ_IDX_W   = $clog2(NUM_REQ_DEF);
  localparam int MAX_REQ     = 8;

  typedef logic [REQ_IDX_W-1:0] owner_t;

  // Returns {found, idx}: first set bit of req at or after ptr, mod n.
  function automatic logic [3:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [2:0]         ptr,
    input int                 n
  );
    logic       found;
    logic [2:0] idx;
    int         j;
    found = 1'b0;
    idx   = 3'd0;
    for (int k = 0; k < MAX_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= n) j = j - n;
      if (!found && (k < n) && req[j[2:0]]) begin
        found = 1'b1;
        idx   = j[2:0];
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/resource_arb_tag_fifo.sv
// resource_arb_tag_fifo: synchronous FIFO of owner tags.
// A pop frees a slot for a same-cycle push when full.
module resource_arb_tag_fifo
  import resource_arb_pkg::*;
#(
  parameter int W     = 2,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [AW:0]   r_cnt;
  logic          w_pop;
  logic          w_push;

  assign empty  = (r_cnt == '0);
  assign full   = (r_cnt == (AW+1)'(DEPTH));
  assign head   = r_mem[r_rd];
  assign count  = r_cnt;
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/resource_arbiter.sv
// resource_arbiter: round-robin share of one in-order resource.
// Optional grant lock for bursts: define ARB_BURST_LOCK_EN.
module resource_arbiter
  import resource_arb_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 8,
  parameter int BURST_MAX       = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ*DATA_W-1:0] in_data_from_req,
  input  logic [NUM_REQ-1:0]        in_valid_from_req,
  input  logic [NUM_REQ-1:0]        in_flush_from_req,
  output logic [NUM_REQ-1:0]        out_stall_to_req,
  output logic [DATA_W-1:0]         out_data_to_resource,
  output logic                      out_valid_to_resource,
  output logic                      out_flush_to_resource,
  input  logic                      in_stall_from_resource,
  input  logic [DATA_W-1:0]         in_data_from_resource,
  input  logic                      in_valid_from_resource,
  input  logic                      in_flush_from_resource,
  output logic                      out_stall_to_resource,
  output logic [NUM_REQ*DATA_W-1:0] out_data_to_req,
  output logic [NUM_REQ-1:0]        out_valid_to_req,
  output logic [NUM_REQ-1:0]        out_flush_to_req,
  input  logic [NUM_REQ-1:0]        in_stall_from_req,
  output logic                      out_err_unexpected_rsp
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  function automatic logic [IW-1:0] f_inc(input logic [IW-1:0] v);
    return (int'(v) == NUM_REQ - 1) ? '0 : v + 1'b1;
  endfunction

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_flush;
  logic [IW-1:0]     r_owner;
  logic [IW-1:0]     r_rr_ptr;
  logic              r_err;

  logic [3:0]        w_pick;
  logic [IW-1:0]     w_winner;
  logic              w_free;
  logic              w_room;
  logic              w_accept;
  logic [IW-1:0]     w_rr_next;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [IW-1:0]     w_head;
  logic [CW-1:0]     w_count;

  assign w_pick   = rr_pick(MAX_REQ'(in_valid_from_req),
                            3'(r_rr_ptr), NUM_REQ);
  assign w_winner = IW'(w_pick[2:0]);
  assign w_free   = ~r_valid | ~in_stall_from_resource;
  assign w_room   = ({1'b0, w_count} + (CW+1)'(r_valid))
                    < (CW+1)'(MAX_OUTSTANDING);
  assign w_accept = ~reset & w_free & w_room & w_pick[3];

  always_comb begin
    out_stall_to_req = '1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_accept && (w_winner == IW'(i)))
        out_stall_to_req[i] = 1'b0;
    end
  end

`ifdef ARB_BURST_LOCK_EN
  localparam int BW = $clog2(BURST_MAX + 1);

  logic          r_lock_act;
  logic [IW-1:0] r_lock_idx;
  logic [BW-1:0] r_lock_cnt;
  logic [BW-1:0] w_cnt_next;
  logic          w_lock_end;

  // While locked, rr_ptr parks on the owner so it wins the search.
  always_comb begin
    w_cnt_next = (r_lock_act && (w_winner == r_lock_idx))
                 ? r_lock_cnt + BW'(1) : BW'(1);
    w_lock_end = (w_cnt_next == BW'(BURST_MAX));
    w_rr_next  = r_rr_ptr;
    if (w_accept)
      w_rr_next = w_lock_end ? f_inc(w_winner) : w_winner;
    else if (r_lock_act && !in_valid_from_req[r_lock_idx])
      w_rr_next = f_inc(r_lock_idx);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lock_act <= 1'b0;
      r_lock_idx <= '0;
      r_lock_cnt <= '0;
    end else if (w_accept) begin
      r_lock_act <= ~w_lock_end;
      r_lock_idx <= w_winner;
      r_lock_cnt <= w_lock_end ? '0 : w_cnt_next;
    end else if (r_lock_act && !in_valid_from_req[r_lock_idx]) begin
      r_lock_act <= 1'b0;
      r_lock_cnt <= '0;
    end
  end
`else
  assign w_rr_next = w_accept ? f_inc(w_winner) : r_rr_ptr;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_flush  <= 1'b0;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_data  <= in_data_from_req[w_winner*DATA_W +: DATA_W];
        r_flush <= in_flush_from_req[w_winner];
        r_valid <= 1'b1;
        r_owner <= w_winner;
      end else if (w_free) begin
        r_valid <= 1'b0;
      end
      r_rr_ptr <= w_rr_next;
      if (in_valid_from_resource && w_empty) r_err <= 1'b1;
    end
  end

  assign out_data_to_resource   = r_data;
  assign out_valid_to_resource  = r_valid;
  assign out_flush_to_resource  = r_flush;
  assign out_err_unexpected_rsp = r_err;

  assign w_push = r_valid & ~in_stall_from_resource;
  assign w_pop  = in_valid_from_resource & ~out_stall_to_resource;

  resource_arb_tag_fifo #(
    .W     (IW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tags (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .din   (r_owner),
    .pop   (w_pop),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head),
    .count (w_count)
  );

  assign out_stall_to_resource = w_empty | in_stall_from_req[w_head];
  assign out_data_to_req = {NUM_REQ{in_data_from_resource}};

  always_comb begin
    out_valid_to_req = '0;
    out_flush_to_req = '0;
    out_valid_to_req[w_head] = in_valid_from_resource & ~w_empty;
    out_flush_to_req[w_head] = in_flush_from_resource & ~w_empty;
  end

  logic w_unused;
  assign w_unused = w_full;

endmodule

// File: tb/tb_resource_arbiter.sv
// tb_resource_arbiter: directed vectors for resource_arbiter.
// Set ARB_BURST_LOCK_EN to match a burst-lock build.
module tb_resource_arbiter;
  import resource_arb_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] in_data_from_req;
  logic [3:0]   in_valid_from_req;
  logic [3:0]   in_flush_from_req;
  logic [3:0]   out_stall_to_req;
  logic [31:0]  out_data_to_resource;
  logic         out_valid_to_resource;
  logic         out_flush_to_resource;
  logic         in_stall_from_resource;
  logic [31:0]  in_data_from_resource;
  logic         in_valid_from_resource;
  logic         in_flush_from_resource;
  logic         out_stall_to_resource;
  logic [127:0] out_data_to_req;
  logic [3:0]   out_valid_to_req;
  logic [3:0]   out_flush_to_req;
  logic [3:0]   in_stall_from_req;
  logic         out_err_unexpected_rsp;

  int nvec = 0;
  int nerr = 0;
  int exp1 [4];
  int exp6 [8];
  int e2;
  owner_t w;

  resource_arbiter #(
    .NUM_REQ(4), .DATA_W(32),
    .MAX_OUTSTANDING(8), .BURST_MAX(4)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .in_data_from_req       (in_data_from_req),
    .in_valid_from_req      (in_valid_from_req),
    .in_flush_from_req      (in_flush_from_req),
    .out_stall_to_req       (out_stall_to_req),
    .out_data_to_resource   (out_data_to_resource),
    .out_valid_to_resource  (out_valid_to_resource),
    .out_flush_to_resource  (out_flush_to_resource),
    .in_stall_from_resource (in_stall_from_resource),
    .in_data_from_resource  (in_data_from_resource),
    .in_valid_from_resource (in_valid_from_resource),
    .in_flush_from_resource (in_flush_from_resource),
    .out_stall_to_resource  (out_stall_to_resource),
    .out_data_to_req        (out_data_to_req),
    .out_valid_to_req       (out_valid_to_req),
    .out_flush_to_req       (out_flush_to_req),
    .in_stall_from_req      (in_stall_from_req),
    .out_err_unexpected_rsp (out_err_unexpected_rsp)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    in_valid_from_req      = 4'h0;
    in_stall_from_resource = 1'b0;
    in_valid_from_resource = 1'b0;
    in_flush_from_resource = 1'b0;
    in_data_from_resource  = 32'h0;
    in_stall_from_req      = 4'h0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  function automatic logic [3:0] nstall(input int i);
    return ~(4'b0001 << i);
  endfunction

  initial begin
`ifdef ARB_BURST_LOCK_EN
    exp1 = '{0, 0, 0, 0};
    exp6 = '{0, 0, 0, 0, 1, 1, 1, 1};
    e2   = 0;
`else
    exp1 = '{0, 2, 0, 2};
    exp6 = '{0, 1, 0, 1, 0, 1, 0, 1};
    e2   = 1;
`endif
    in_data_from_req = {32'hA5A5_0003, 32'hA5A5_0002,
                        32'hA5A5_0001, 32'hA5A5_0000};
    in_flush_from_req = 4'b0100;
    idle();
    reset = 1'b1;
    in_valid_from_req = 4'hF;
    step();
    step();
    chk("rst_valid", out_valid_to_resource, 0);
    chk("rst_data", out_data_to_resource, 0);
    chk("rst_flush", out_flush_to_resource, 0);
    chk("rst_stall_req", out_stall_to_req, 4'hF);
    chk("rst_stall_res", out_stall_to_resource, 1);
    chk("rst_err", out_err_unexpected_rsp, 0);
    reset = 1'b0;
    in_valid_from_req = 4'b0101;
    #1;

    for (int k = 0; k < 4; k++) begin
      chk("t1_stall", out_stall_to_req, nstall(exp1[k]));
      step();
      chk("t1_valid", out_valid_to_resource, 1);
      chk("t1_data", out_data_to_resource,
          32'hA5A5_0000 | exp1[k]);
      chk("t1_flush", out_flush_to_resource, exp1[k] == 2);
    end
    in_valid_from_req = 4'h0;
    step();
    chk("t1_drain", out_valid_to_resource, 0);

    do_reset();
    in_valid_from_req = 4'hF;
    #1;
    chk("t2_first", out_stall_to_req, 4'b1110);
    step();
    in_stall_from_resource = 1'b1;
    #1;
    chk("t2_stall0", out_stall_to_req, 4'hF);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t2_hold_data", out_data_to_resource, 32'hA5A5_0000);
      chk("t2_hold_valid", out_valid_to_resource, 1);
      chk("t2_hold_stall", out_stall_to_req, 4'hF);
    end
    in_stall_from_resource = 1'b0;
    #1;
    chk("t2_resume", out_stall_to_req, nstall(e2));
    step();
    chk("t2_resume_data", out_data_to_resource, 32'hA5A5_0000 | e2);

    do_reset();
    in_valid_from_req = 4'b0010;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("t3_fill", out_stall_to_req, 4'b1101);
      step();
    end
    for (int k = 0; k < 3; k++) begin
      chk("t3_full", out_stall_to_req, 4'hF);
      step();
    end
    chk("t3_idle", out_valid_to_resource, 0);
    in_valid_from_resource = 1'b1;
    in_data_from_resource  = 32'h0000_1234;
    #1;
    chk("t3_pop_v", out_valid_to_req, 4'b0010);
    chk("t3_pop_d", out_data_to_req[32 +: 32], 32'h0000_1234);
    chk("t3_pop_s", out_stall_to_req, 4'hF);
    step();
    in_valid_from_resource = 1'b0;
    #1;
    chk("t3_room", out_stall_to_req, 4'b1101);
    step();
    in_valid_from_resource = 1'b1;
    #1;
    chk("t3_pp_v", out_valid_to_req, 4'b0010);
    chk("t3_pp_s", out_stall_to_req, 4'hF);
    step();
    in_valid_from_req = 4'h0;
    #1;
    for (int k = 0; k < 7; k++) begin
      chk("t3_drain_s", out_stall_to_resource, 0);
      chk("t3_drain_v", out_valid_to_req, 4'b0010);
      step();
    end
    in_valid_from_resource = 1'b0;
    #1;
    chk("t3_empty", out_stall_to_resource, 1);
    chk("t3_err", out_err_unexpected_rsp, 0);

    do_reset();
    in_valid_from_req = 4'b0010;
    step();
    in_valid_from_req = 4'b1000;
    step();
    in_valid_from_req = 4'b0010;
    step();
    in_valid_from_req = 4'b0000;
    step();
    in_stall_from_req      = 4'b1000;
    in_valid_from_resource = 1'b1;
    in_data_from_resource  = 32'hA5A5_0001;
    #1;
    chk("t4_r0_v", out_valid_to_req, 4'b0010);
    chk("t4_r0_s", out_stall_to_resource, 0);
    step();
    in_data_from_resource = 32'hA5A5_0003;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("t4_r1_held", out_stall_to_resource, 1);
      chk("t4_r1_v", out_valid_to_req, 4'b1000);
      step();
    end
    in_stall_from_req = 4'b0000;
    #1;
    chk("t4_r1_go", out_stall_to_resource, 0);
    chk("t4_r1_d", out_data_to_req[96 +: 32], 32'hA5A5_0003);
    step();
    in_data_from_resource  = 32'hA5A5_0001;
    in_flush_from_resource = 1'b1;
    #1;
    chk("t4_r2_v", out_valid_to_req, 4'b0010);
    chk("t4_r2_f", out_flush_to_req, 4'b0010);
    step();
    in_valid_from_resource = 1'b0;
    in_flush_from_resource = 1'b0;
    #1;
    chk("t4_empty", out_stall_to_resource, 1);
    chk("t4_err", out_err_unexpected_rsp, 0);

    in_valid_from_resource = 1'b1;
    #1;
    chk("t5_novalid", out_valid_to_req, 4'h0);
    step();
    in_valid_from_resource = 1'b0;
    #1;
    chk("t5_err", out_err_unexpected_rsp, 1);
    in_valid_from_req = 4'hF;
    step();
    step();
    chk("t5_err_sticky", out_err_unexpected_rsp, 1);
    chk("t5_busy", out_valid_to_resource, 1);
    reset = 1'b1;
    step();
    chk("t5_rst_valid", out_valid_to_resource, 0);
    chk("t5_rst_data", out_data_to_resource, 0);
    chk("t5_rst_flush", out_flush_to_resource, 0);
    chk("t5_rst_stall", out_stall_to_req, 4'hF);
    chk("t5_rst_res", out_stall_to_resource, 1);
    chk("t5_rst_err", out_err_unexpected_rsp, 0);
    reset = 1'b0;
    #1;
    chk("t5_rr_ptr", out_stall_to_req, 4'b1110);
    in_valid_from_req      = 4'h0;
    in_valid_from_resource = 1'b1;
    #1;
    chk("t5_stale_v", out_valid_to_req, 4'h0);
    step();
    in_valid_from_resource = 1'b0;
    #1;
    chk("t5_stale_err", out_err_unexpected_rsp, 1);

    do_reset();
    in_valid_from_req = 4'b0011;
    #1;
    for (int k = 0; k < 8; k++) begin
      w = owner_t'(exp6[k]);
      chk("t6_grant", out_stall_to_req, nstall(int'(w)));
      step();
      chk("t6_data", out_data_to_resource, 32'hA5A5_0000 | exp6[k]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
